i2c_cmd_seq: RTL



---
 rtl/i2c_seq_pkg.sv | 23 ++
 rtl/i2c_cmd_fifo.sv | 47 ++++
 rtl/i2c_cmd_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, the queued command
// record and the data_sel encodings of the master's byte port.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_A, ST_WT_A, ST_LD_R, ST_WT_R, ST_LD_D, ST_WT_D
  } state_e;

  typedef struct packed {
    logic [6:0] slv_addr;
    logic [7:0] reg_idx;
    logic [7:0] data;
  } cmd_t;

  localparam int   CMD_W    = $bits(cmd_t);
  localparam logic SEL_CTRL = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  function automatic logic is_wait(input state_e s);
    return (s == ST_WT_A) || (s == ST_WT_R) || (s == ST_WT_D);
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Show-ahead synchronous FIFO; push while full and pop while empty are ignored.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // storage needs no reset; count and pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/i2c_cmd_seq.sv
// Replays queued register-write commands as address/register/data byte loads
// into an I2C master, waiting on the completion interrupt after each byte.
module i2c_cmd_seq
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic       pclk,
  input  logic       prst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_slv_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic [7:0] data_in,
  output logic       data_sel,
  output logic       data_wr,
  output logic       apb_we,
  output logic       apb_re,
  input  logic       i2c_if,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  cmd_t                cmd_q, fifo_rdata, fifo_wdata;
  logic [CW-1:0]       cnt_q;
  logic                i2c_if_q;
  logic                fifo_full, fifo_empty, push, pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                rise, wait_st, to_hit;
  logic [7:0]          data_in_q, data_in_d;
  logic                data_sel_q, data_sel_d, data_wr_q, data_wr_d;
  logic                done_q, done_d, err_q, err_d;

  assign fifo_wdata = '{slv_addr: cmd_slv_addr, reg_idx: cmd_reg, data: cmd_data};
  assign push       = cmd_valid & ~fifo_full;
  assign pop        = (state_q == ST_IDLE) & ~fifo_empty;

  i2c_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk_i   (pclk),
    .rst_i   (prst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rise    = i2c_if & ~i2c_if_q;
  assign wait_st = is_wait(state_q);
  // a rise on the deciding edge wins over the timeout
  assign to_hit  = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (prst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LD_A;
      ST_LD_A: state_d = ST_WT_A;
      ST_WT_A: if (rise) state_d = ST_LD_R; else if (to_hit) state_d = ST_IDLE;
      ST_LD_R: state_d = ST_WT_R;
      ST_WT_R: if (rise) state_d = ST_LD_D; else if (to_hit) state_d = ST_IDLE;
      ST_LD_D: state_d = ST_WT_D;
      ST_WT_D: if (rise || to_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_in_d  = data_in_q;
    data_sel_d = data_sel_q;
    data_wr_d  = 1'b0;
    done_d     = (state_q == ST_WT_D) & rise;
    err_d      = wait_st & ~rise & to_hit;
    unique case (state_q)
      ST_LD_A: begin data_in_d = {cmd_q.slv_addr, 1'b0}; data_sel_d = SEL_CTRL; data_wr_d = 1'b1; end
      ST_LD_R: begin data_in_d = cmd_q.reg_idx;          data_sel_d = SEL_DATA; data_wr_d = 1'b1; end
      ST_LD_D: begin data_in_d = cmd_q.data;             data_sel_d = SEL_DATA; data_wr_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      cmd_q      <= '0;
      cnt_q      <= '0;
      i2c_if_q   <= 1'b0;
      data_in_q  <= '0;
      data_sel_q <= 1'b0;
      data_wr_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      i2c_if_q   <= i2c_if;
      cnt_q      <= wait_st ? cnt_q + CW'(1) : '0;
      if (pop) cmd_q <= fifo_rdata;
      data_in_q  <= data_in_d;
      data_sel_q <= data_sel_d;
      data_wr_q  <= data_wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ~fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);
  assign data_in   = data_in_q;
  assign data_sel  = data_sel_q;
  assign data_wr   = data_wr_q;
  assign apb_we    = data_wr_q;
  assign apb_re    = 1'b0;
  assign done      = done_q;
  assign err       = err_q;

endmodule
